// File: rtl/digit_scan_ctrl.sv
// Multiplexed 4-digit BCD display scanner.
// Accepts a 16-bit BCD value through a valid/ready handshake, holds a new
// value in a one-deep pending register until the current frame completes,
// and scans the four digits with a programmable per-digit dwell time.
// Leading-zero blanking is optional; out-of-range nibbles raise a sticky flag.
module digit_scan_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_value,
  output logic        in_ready,
  output logic [3:0]  num,
  output logic [3:0]  dig_n,
  output logic        bcd_err
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Prescaler wide enough for the largest legal dwell (2^20 cycles).
  localparam int            PW   = 20;
  localparam logic [PW-1:0] TERM = PW'(SCAN_DIV - 1);

  // True when any nibble of the value is outside 0..9.
  function automatic logic bad_bcd(input logic [15:0] v);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (v[4*k +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Digit idx is blanked when it and every higher nibble are zero; digit 0
  // always stays lit so a zero value still shows a single "0".
  function automatic logic blank_digit(input logic [15:0] v, input logic [1:0] idx);
    logic [15:0] upper;
    upper = v >> {idx, 2'b00};
    return BLANK_LZ && (idx != 2'd0) && (upper == 16'h0000);
  endfunction

  state_t         state_q, state_d;
  logic [15:0]    disp_q, disp_d;
  logic [15:0]    pend_q, pend_d;
  logic           pend_full_q, pend_full_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [1:0]     idx_q, idx_d;
  logic [3:0]     num_q, num_d;
  logic [3:0]     dig_n_q, dig_n_d;
  logic           bcd_err_q, bcd_err_d;

  logic           xfer;
  logic           slot_end;
  logic           frame_end;

  assign in_ready  = ~pend_full_q;
  assign xfer      = in_valid & in_ready;
  assign slot_end  = (presc_q == TERM);
  assign frame_end = slot_end && (idx_q == 2'd3);

  assign num     = num_q;
  assign dig_n   = dig_n_q;
  assign bcd_err = bcd_err_q;

  // State register and all datapath registers; reset clears every held value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      disp_q      <= 16'h0000;
      pend_q      <= 16'h0000;
      pend_full_q <= 1'b0;
      presc_q     <= '0;
      idx_q       <= 2'd0;
      num_q       <= 4'h0;
      dig_n_q     <= 4'hF;
      bcd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      num_q       <= num_d;
      dig_n_q     <= dig_n_d;
      bcd_err_q   <= bcd_err_d;
    end
  end

  // Next-state, scan timing, frame-aligned value swap and registered digit drive.
  always_comb begin
    state_d     = state_q;
    disp_d      = disp_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    presc_d     = presc_q;
    idx_d       = idx_q;
    num_d       = 4'h0;
    dig_n_d     = 4'hF;
    bcd_err_d   = bcd_err_q | (xfer & bad_bcd(in_value));

    case (state_q)
      IDLE: begin
        // First value bypasses pending and starts a frame straight away.
        if (xfer) begin
          disp_d  = in_value;
          state_d = SCAN;
          presc_d = '0;
          idx_d   = 2'd0;
        end
      end

      SCAN: begin
        num_d = disp_q[{idx_q, 2'b00} +: 4];
        if (!blank_digit(disp_q, idx_q)) begin
          dig_n_d = ~(4'b0001 << idx_q);
        end

        if (slot_end) begin
          presc_d = '0;
          idx_d   = idx_q + 2'd1;
        end else begin
          presc_d = presc_q + PW'(1);
        end

        // Swap only at the frame boundary so a frame never mixes two values.
        // A full pending register blocks in_ready, so no transfer collides here.
        if (frame_end && pend_full_q) begin
          disp_d      = pend_q;
          pend_full_d = 1'b0;
        end else if (xfer) begin
          pend_d      = in_value;
          pend_full_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl with a 4-cycle dwell and leading-zero blanking.
// A frame-time model predicts the outputs every cycle; directed frames pin
// the digit patterns with hand-computed values.
module tb_digit_scan_ctrl;

  localparam int SCAN_DIV = 4;
  localparam bit BLANK_LZ = 1'b1;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_value;
  logic        in_ready;
  logic [3:0]  num;
  logic [3:0]  dig_n;
  logic        bcd_err;

  int checks = 0;
  int errors = 0;

  digit_scan_ctrl #(
    .SCAN_DIV (SCAN_DIV),
    .BLANK_LZ (BLANK_LZ)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_value (in_value),
    .in_ready (in_ready),
    .num      (num),
    .dig_n    (dig_n),
    .bcd_err  (bcd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a display is active once a value arrives; a frame is FRAME cycles,
  // digit = frame time / SCAN_DIV; pending swaps in at the end of a frame.
  bit          m_init = 1'b0;
  bit          m_act, m_pfull, m_err;
  logic [15:0] m_disp, m_pend;
  int          m_t;
  logic [3:0]  e_dig, e_num;

  always @(posedge clk) begin
    int          d;
    logic [15:0] sh;
    bit          xfer, bad;
    if (!rst_n) begin
      m_act = 0; m_pfull = 0; m_err = 0; m_disp = 0; m_pend = 0; m_t = 0;
      e_dig = 4'hF; e_num = 4'h0; m_init = 1'b1;
    end else if (m_init) begin
      if (!m_act) begin
        e_dig = 4'hF; e_num = 4'h0;
      end else begin
        d  = m_t / SCAN_DIV;
        sh = m_disp >> (4 * d);
        e_num = sh[3:0];
        if (BLANK_LZ && d != 0 && sh == 16'h0) e_dig = 4'hF;
        else e_dig = ~(4'b0001 << d);
      end
      xfer = in_valid && !m_pfull;
      bad = 0;
      for (int k = 0; k < 4; k++) if (in_value[4*k +: 4] > 4'd9) bad = 1;
      if (xfer && bad) m_err = 1;
      if (!m_act) begin
        if (xfer) begin m_disp = in_value; m_act = 1; m_t = 0; end
      end else begin
        if (m_t == FRAME - 1 && m_pfull) begin
          m_disp = m_pend; m_pfull = 0;
        end else if (xfer) begin
          m_pend = in_value; m_pfull = 1;
        end
        m_t = (m_t == FRAME - 1) ? 0 : m_t + 1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_init) begin
      chk("model dig_n", {12'h0, dig_n}, {12'h0, e_dig});
      chk("model num", {12'h0, num}, {12'h0, e_num});
      chk("model in_ready", {15'h0, in_ready}, {15'h0, !m_pfull});
      chk("model bcd_err", {15'h0, bcd_err}, {15'h0, m_err});
    end
  end

  // Checks 16 consecutive cycles of a frame against per-digit literals.
  task automatic frame_check(input string name, input logic [15:0] digs, input logic [15:0] nums);
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      chk({name, " dig_n"}, {12'h0, dig_n}, {12'h0, digs[(j / SCAN_DIV) * 4 +: 4]});
      chk({name, " num"}, {12'h0, num}, {12'h0, nums[(j / SCAN_DIV) * 4 +: 4]});
    end
  endtask

  // Sends a value at the start of a frame (pending empty), checks that
  // in_ready stays low until the boundary, then checks the new frame.
  task automatic send_frame(input string name, input logic [15:0] v, input logic exp_err,
                            input logic [15:0] digs, input logic [15:0] nums);
    in_valid = 1'b1;
    in_value = v;
    @(negedge clk);
    in_valid = 1'b0;
    chk({name, " ready after accept"}, {15'h0, in_ready}, 16'h0);
    chk({name, " bcd_err"}, {15'h0, bcd_err}, {15'h0, exp_err});
    for (int i = 0; i < FRAME - 1; i++) begin
      @(negedge clk);
      chk({name, " ready hold"}, {15'h0, in_ready}, (i == FRAME - 2) ? 16'h1 : 16'h0);
    end
    frame_check(name, digs, nums);
  endtask

  initial begin
    int          cnt;
    bit          taken;
    logic [15:0] v;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_value = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset dig_n", {12'h0, dig_n}, 16'h000F);
    chk("reset num", {12'h0, num}, 16'h0000);
    chk("reset in_ready", {15'h0, in_ready}, 16'h0001);
    chk("reset bcd_err", {15'h0, bcd_err}, 16'h0000);

    // First value from IDLE goes straight to display.
    in_valid = 1'b1;
    in_value = 16'h1234;
    @(negedge clk);
    in_valid = 1'b0;
    chk("idle exit dig_n", {12'h0, dig_n}, 16'h000F);
    frame_check("h1234", {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {4'h1, 4'h2, 4'h3, 4'h4});

    // New value mid-scan waits for the boundary; upper zeros blanked.
    send_frame("h0042", 16'h0042, 1'b0, {4'b1111, 4'b1111, 4'b1101, 4'b1110}, {4'h0, 4'h0, 4'h4, 4'h2});
    send_frame("h0000", 16'h0000, 1'b0, {4'b1111, 4'b1111, 4'b1111, 4'b1110}, 16'h0000);
    send_frame("h1000", 16'h1000, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {4'h1, 4'h0, 4'h0, 4'h0});
    send_frame("h00A5", 16'h00A5, 1'b1, {4'b1111, 4'b1111, 4'b1101, 4'b1110}, {4'h0, 4'h0, 4'hA, 4'h5});
    chk("bcd_err sticky", {15'h0, bcd_err}, 16'h0001);

    // Reset during the digit-2 slot with pending full.
    in_valid = 1'b1;
    in_value = 16'h0777;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("pending full before reset", {15'h0, in_ready}, 16'h0000);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid reset dig_n", {12'h0, dig_n}, 16'h000F);
    chk("mid reset num", {12'h0, num}, 16'h0000);
    chk("mid reset in_ready", {15'h0, in_ready}, 16'h0001);
    chk("mid reset bcd_err", {15'h0, bcd_err}, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle after reset dig_n", {12'h0, dig_n}, 16'h000F);
    end

    // Continuous in_valid: one transfer per frame, right after each boundary.
    cnt   = 0;
    taken = 0;
    v     = 16'h1111;
    in_valid = 1'b1;
    for (int i = 0; i < 5 * FRAME; i++) begin
      if (taken) v = v + 16'h1111;
      in_value = v;
      taken = in_ready;
      if (taken) cnt++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("streaming transfer count", 16'(cnt), 16'd6);
    repeat (2 * FRAME) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_scan_ctrl.md
DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clock cycles each digit is held active (legal range 2..2^20).
REQ-002 Parameter BLANK_LZ, default 1, 1 enables leading-zero blanking and 0 disables it.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  new display value offered.
REQ-006 in_value  input  16  four BCD nibbles; [3:0] is digit 0 (rightmost) and [15:12] is digit 3.
REQ-007 in_ready  output  1  block can accept in_value.
REQ-008 num  output  4  BCD code of the active digit, driven to the downstream segment decoder.
REQ-009 dig_n  output  4  digit enables, active-low, one-hot-low when a digit is shown.
REQ-010 bcd_err  output  1  sticky flag, set when an accepted value contains a nibble above 9.

Function
REQ-011 The state machine SHALL have two states: IDLE (no value yet, all digits off) and SCAN.
REQ-012 A transfer SHALL occur on any cycle where in_valid and in_ready are both 1; in_value is captured into the pending register.
REQ-013 in_ready SHALL be 1 exactly when the pending register is empty.
REQ-014 In IDLE, a transfer SHALL load the value directly into the display register, leave pending empty, and move to SCAN on the next cycle with digit index 0 and prescaler 0.
REQ-015 In SCAN, a transfer SHALL fill pending; in_ready SHALL drop the following cycle.
REQ-016 The prescaler SHALL count 0..SCAN_DIV-1; at terminal count it wraps to 0 and the digit index advances 0->1->2->3->0.
REQ-017 On the 3->0 wrap (frame boundary), a full pending register SHALL be copied into the display register and pending SHALL empty, so in_ready rises the next cycle; no value tears mid-frame.
REQ-018 A transfer on the same cycle as the frame boundary SHALL be impossible, because in_ready is 0 whenever pending is full; when pending is empty at the boundary, a same-cycle transfer fills pending normally.
REQ-019 num SHALL equal the display-register nibble selected by the digit index; dig_n SHALL drive bit[index] low and all other bits high.
REQ-020 With BLANK_LZ=1, digit k (k>=1) SHALL be blanked (dig_n all 1s) while it and every higher nibble are 0; digit 0 is never blanked.
REQ-021 A blanked digit SHALL still consume its full SCAN_DIV slot, so the frame length is always 4*SCAN_DIV cycles.
REQ-022 num and dig_n SHALL be registered, changing one cycle after the index or display-register update.
REQ-023 bcd_err SHALL set on the cycle after a transfer with any nibble in 10..15, and clears only on reset; the value is still accepted and displayed.
REQ-024 In IDLE, outputs SHALL be dig_n=4'b1111 and num=0.

Reset
REQ-025 When rst_n=0 at a clock edge, the block SHALL enter IDLE with display and pending registers 0, pending empty, prescaler 0, index 0, dig_n=4'b1111, num=0, bcd_err=0, and in_ready=1 from the first cycle after release.
REQ-026 Reset asserted mid-frame or with pending full SHALL discard all held values; no partial digit slot continues.

Verification
REQ-027 Reset, SCAN_DIV=4, transfer 16'h1234: IDLE exit, then dig_n cycles 1110/1101/1011/0111 with num 4,3,2,1, each held 4 cycles, frame length 16 cycles.
REQ-028 In SCAN, send 16'h0042 mid-frame: in_ready=0 until the boundary; the old value finishes its frame; the new frame shows 2,4 on digits 0,1 and digits 2,3 blanked (dig_n=1111 during their slots).
REQ-029 Value 16'h0000 with BLANK_LZ=1: only digit 0 lit with num=0; value 16'h1000 lights all four digits.
REQ-030 Transfer 16'h00A5: bcd_err=1 the cycle after acceptance and stays 1 until reset; num=4'hA is shown on digit 1.
REQ-031 Assert rst_n=0 for 1 cycle during the digit-2 slot with pending full: dig_n=1111 next cycle, in_ready=1, IDLE; no further digits light until a new transfer.
REQ-032 Hold in_valid=1 continuously: exactly one transfer per frame, each occurring on the cycle after a frame boundary, with no value dropped or duplicated.
